// File: rtl/serial_bcd_result_rx.sv
// Deserialises the 20-bit BCD ALU result shifted out after each operand frame.
// Define BCD_CHECK_EN to build the per-digit range check that drives res_err.
module serial_bcd_result_rx #(
  parameter int unsigned SKIP  = 1,
  parameter int unsigned NBITS = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sdata,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [NBITS-1:0] res,
  output logic             res_err,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned SKIP_W = 3;
  localparam int unsigned NDIG   = NBITS / 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [NBITS-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic              en_q;
  logic              sample_c;
  logic              load_c;
  logic [NBITS-1:0]  res_d;
  logic              res_valid_d;
  logic              busy_d;
  logic              overrun_d;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a rising en during WAIT/SHIFT aborts the frame
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (en) state_d = S_ARMED;
      S_ARMED: if (!en) state_d = (SKIP == 0) ? S_SHIFT : S_WAIT;
      S_WAIT: begin
        if (en)                                   state_d = S_ARMED;
        else if (skip_cnt_q == SKIP_W'(SKIP))     state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (en)                                   state_d = S_ARMED;
        else if (bit_cnt_q == CNT_W'(NBITS - 1))  state_d = S_DONE;
      end
      S_DONE:  if (res_ready) state_d = en ? S_ARMED : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    skip_cnt_d  = skip_cnt_q;
    res_d       = res;
    res_valid_d = res_valid;
    overrun_d   = overrun;
    sample_c    = 1'b0;
    unique case (state_q)
      S_ARMED: begin
        bit_cnt_d  = '0;
        skip_cnt_d = '0;
        if (!en) begin
          if (SKIP == 0) sample_c   = 1'b1;
          else           skip_cnt_d = SKIP_W'(1);
        end
      end
      S_WAIT: begin
        if (!en) begin
          if (skip_cnt_q == SKIP_W'(SKIP)) sample_c   = 1'b1;
          else                             skip_cnt_d = skip_cnt_q + SKIP_W'(1);
        end
      end
      S_SHIFT: if (!en) sample_c = 1'b1;
      S_DONE: begin
        if (res_ready)         res_valid_d = 1'b0;
        else if (en_q && !en)  overrun_d   = 1'b1;
      end
      default: ;
    endcase
    if (sample_c) begin
      sr_d      = {sr_q[NBITS-2:0], sdata};
      bit_cnt_d = bit_cnt_d + CNT_W'(1);
    end
    load_c = (state_q != S_DONE) && (state_d == S_DONE);
    if (load_c) begin
      res_d       = sr_d;
      res_valid_d = 1'b1;
    end
    busy_d = (state_d == S_WAIT) || (state_d == S_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      skip_cnt_q <= '0;
      en_q       <= 1'b0;
      res        <= '0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      skip_cnt_q <= skip_cnt_d;
      en_q       <= en;
      res        <= res_d;
      res_valid  <= res_valid_d;
      busy       <= busy_d;
      overrun    <= overrun_d;
    end
  end

`ifdef BCD_CHECK_EN
  function automatic logic has_bad_digit(input logic [NBITS-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int d = 0; d < NDIG; d++) begin
      if (w[d*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Error flag is captured with res on DONE entry
  always_ff @(posedge clk) begin
    if (!rst_n)      res_err <= 1'b0;
    else if (load_c) res_err <= has_bad_digit(sr_d);
  end
`else
  assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_bcd_result_rx.sv
// Bench for serial_bcd_result_rx: two instances (SKIP=1 and SKIP=0) share one
// serial stream; each result is predicted as a 20-bit window of that stream.
module tb_serial_bcd_result_rx;

  localparam int unsigned SKIP_A   = 1;
  localparam int unsigned SKIP_B   = 0;
  localparam int unsigned SKIP_MAX = 1;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        sdata;
  logic        res_ready;
  logic        res_valid_a, res_err_a, busy_a, overrun_a;
  logic [19:0] res_a;
  logic        res_valid_b, res_err_b, busy_b, overrun_b;
  logic [19:0] res_b;

  int n_vec = 0;
  int n_err = 0;

  serial_bcd_result_rx #(.SKIP(SKIP_A), .NBITS(20)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .sdata(sdata), .res_ready(res_ready),
    .res_valid(res_valid_a), .res(res_a), .res_err(res_err_a),
    .busy(busy_a), .overrun(overrun_a)
  );

  serial_bcd_result_rx #(.SKIP(SKIP_B), .NBITS(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .sdata(sdata), .res_ready(res_ready),
    .res_valid(res_valid_b), .res(res_b), .res_err(res_err_b),
    .busy(busy_b), .overrun(overrun_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream bit 20 goes out at k0; a receiver with skip k sees the 20 bits starting k edges later
  function automatic logic [19:0] window(input logic [20:0] s, input int unsigned skip);
    return 20'(s >> (SKIP_MAX - skip));
  endfunction

  function automatic logic bad_bcd(input logic [19:0] w);
    logic bad;
    bad = 1'b0;
`ifdef BCD_CHECK_EN
    for (int d = 0; d < 5; d++) if (4'(w >> (4 * d)) > 4'd9) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [19:0] rand_bcd();
    logic [19:0] w;
    w = '0;
    for (int d = 0; d < 5; d++) w = {w[15:0], 4'($urandom_range(0, 9))};
    return w;
  endfunction

  // en high for hi cycles, then low while the stream goes out; record first-valid edge index
  task automatic drive_frame(input logic [20:0] s, input int hi, input bit fresh,
                             output int lat_a, output int lat_b);
    lat_a = 0;
    lat_b = 0;
    en = 1'b1;
    for (int i = 0; i < hi; i++) begin
      sdata = 1'($urandom);
      @(negedge clk);
    end
    for (int j = 0; j < 23; j++) begin
      en    = 1'b0;
      sdata = (j < 21) ? s[5'(20 - j)] : 1'($urandom);
      @(negedge clk);
      if (lat_a == 0 && res_valid_a === 1'b1) lat_a = j + 1;
      if (lat_b == 0 && res_valid_b === 1'b1) lat_b = j + 1;
      if (fresh && j == 0) begin
        check("busy_a_after_k0", 32'(busy_a), 32'd1);
        check("busy_b_after_k0", 32'(busy_b), 32'd1);
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [20:0] s, input int la, input int lb);
    logic [19:0] ea, eb;
    ea = window(s, SKIP_A);
    eb = window(s, SKIP_B);
    check($sformatf("%s.res_a", tag),   32'(res_a),       32'(ea));
    check($sformatf("%s.err_a", tag),   32'(res_err_a),   32'(bad_bcd(ea)));
    check($sformatf("%s.valid_a", tag), 32'(res_valid_a), 32'd1);
    check($sformatf("%s.busy_a", tag),  32'(busy_a),      32'd0);
    check($sformatf("%s.lat_a", tag),   32'(la),          32'(SKIP_A + 20));
    check($sformatf("%s.res_b", tag),   32'(res_b),       32'(eb));
    check($sformatf("%s.err_b", tag),   32'(res_err_b),   32'(bad_bcd(eb)));
    check($sformatf("%s.lat_b", tag),   32'(lb),          32'(SKIP_B + 20));
  endtask

  task automatic accept(input string tag, input logic en_val, input logic [19:0] ea, input logic [19:0] eb);
    en        = en_val;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check($sformatf("%s.acc_valid_a", tag), 32'(res_valid_a), 32'd0);
    check($sformatf("%s.acc_valid_b", tag), 32'(res_valid_b), 32'd0);
    check($sformatf("%s.acc_res_a", tag),   32'(res_a),       32'(ea));
    check($sformatf("%s.acc_res_b", tag),   32'(res_b),       32'(eb));
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s.a", tag), 32'({res_a, res_valid_a, res_err_a, busy_a, overrun_a}), 32'd0);
    check($sformatf("%s.b", tag), 32'({res_b, res_valid_b, res_err_b, busy_b, overrun_b}), 32'd0);
  endtask

  initial begin
    logic [20:0] s, s_keep;
    int          la, lb;
    logic        en_acc;

    rst_n     = 1'b0;
    en        = 1'b0;
    sdata     = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Non-BCD digit frame
    s = {1'b0, 20'h1A999};
    drive_frame(s, 33, 1'b1, la, lb);
    check_frame("f1A999", s, la, lb);
    accept("f1A999", 1'b0, window(s, SKIP_A), window(s, SKIP_B));

    // Reference frame, left unaccepted
    s = {1'b1, 20'h01234};
    drive_frame(s, 33, 1'b1, la, lb);
    check_frame("f01234", s, la, lb);
    s_keep = s;

    // Second frame while DONE: dropped, overrun set, result held
    s = {1'b0, 20'h00007};
    drive_frame(s, 5, 1'b0, la, lb);
    check("ovr_a", 32'(overrun_a), 32'd1);
    check("ovr_b", 32'(overrun_b), 32'd1);
    check("ovr_res_a", 32'(res_a), 32'(window(s_keep, SKIP_A)));
    check("ovr_res_b", 32'(res_b), 32'(window(s_keep, SKIP_B)));
    check("ovr_valid_a", 32'(res_valid_a), 32'd1);
    accept("ovr", 1'b0, window(s_keep, SKIP_A), window(s_keep, SKIP_B));

    // Abort: en rises after 10 samples on the SKIP=1 receiver
    en = 1'b1;
    repeat (3) @(negedge clk);
    for (int j = 0; j < 11; j++) begin
      en    = 1'b0;
      sdata = 1'($urandom);
      @(negedge clk);
    end
    check("abort_busy_before", 32'(busy_a), 32'd1);
    en = 1'b1;
    @(negedge clk);
    check("abort_busy_a", 32'(busy_a), 32'd0);
    check("abort_busy_b", 32'(busy_b), 32'd0);
    check("abort_valid_a", 32'(res_valid_a), 32'd0);
    check("abort_valid_b", 32'(res_valid_b), 32'd0);
    check("abort_ovr_a", 32'(overrun_a), 32'd1);

    s = {1'b1, 20'h99999};
    drive_frame(s, 2, 1'b1, la, lb);
    check_frame("f99999", s, la, lb);
    accept("f99999", 1'b0, window(s, SKIP_A), window(s, SKIP_B));

    // Reset while SKIP=1 receiver samples bit 12
    en = 1'b1;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 13; j++) begin
      en    = 1'b0;
      sdata = 1'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midshift_reset");
    rst_n = 1'b1;
    @(negedge clk);

    s = {1'b0, 20'h50505};
    drive_frame(s, 4, 1'b1, la, lb);
    check_frame("f50505", s, la, lb);
    accept("f50505", 1'b1, window(s, SKIP_A), window(s, SKIP_B));

    // Frame aimed at the SKIP=0 receiver
    s = {20'h00001, 1'($urandom)};
    drive_frame(s, 3, 1'b1, la, lb);
    check("skip0_res", 32'(res_b), 32'h00001);
    check_frame("f00001", s, la, lb);
    accept("f00001", 1'b0, window(s, SKIP_A), window(s, SKIP_B));

    // Randomised frames with random gaps and accept-time en
    for (int n = 0; n < 16; n++) begin
      if (n % 2 == 0) s = {1'($urandom), rand_bcd()};
      else            s = 21'($urandom);
      drive_frame(s, int'($urandom_range(1, 4)), 1'b1, la, lb);
      check_frame($sformatf("rnd%0d", n), s, la, lb);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check($sformatf("rnd%0d.hold_res_a", n), 32'(res_a), 32'(window(s, SKIP_A)));
      en_acc = 1'($urandom);
      accept($sformatf("rnd%0d", n), en_acc, window(s, SKIP_A), window(s, SKIP_B));
    end
    check("final_ovr_a", 32'(overrun_a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_bcd_result_rx.md
# serial_bcd_result_rx

Serial-to-parallel receiver for the BCD ALU result stream. It watches the shared frame enable `en` and, once an operand frame ends, samples the 20-bit, five-digit BCD result the ALU shifts out. It presents the result as a parallel word with a valid/ready handshake and flags non-BCD digits. It sits directly downstream of the serial BCD ALU and feeds the host/display side.

## Interface
Parameters:
- SKIP, default 1: clock edges between the first edge where `en` is sampled low and the first result-bit sample (covers the ALU capture cycle); legal range 0..7.
- NBITS, default 20: result bits per frame; fixed at 20 (five digits) for this design.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  frame enable shared with the ALU; high while operands shift in, low while the result shifts out.
- sdata  in  1  serial result bit from the ALU, MSB first (digit 4 bit 3 first).
- res_ready  in  1  consumer accepts `res` this cycle.
- res_valid  out  1  `res` holds a complete frame.
- res  out  20  five BCD digits; `res[19:16]` is the most significant.
- res_err  out  1  at least one digit of `res` is greater than 9; qualified by `res_valid`.
- busy  out  1  state is WAIT or SHIFT.
- overrun  out  1  sticky; a frame was dropped because the previous result was not yet accepted.

## Operation
- FSM states: IDLE, ARMED, WAIT, SHIFT, DONE.
- IDLE → ARMED when `en` is 1.
- ARMED → WAIT when `en` is 0 (falling edge of frame); this edge is k0. If SKIP is 0, go to SHIFT instead and sample bit 0 at k0.
- WAIT: count SKIP edges including k0. Then SHIFT.
- SHIFT:
  - shift register `sr <= {sr[18:0], sdata}` each edge.
  - 5-bit bit counter; after the 20th sample, go to DONE and load `res` from the assembled word.
- DONE: `res_valid` is 1. On an edge with `res_ready` = 1, go to ARMED if `en` is 1, otherwise IDLE.
- `en` rises during WAIT or SHIFT: the frame is aborted and discarded (no `res_valid`, `overrun` unchanged); next state ARMED.
- In DONE, any `en` 1→0 transition before acceptance sets `overrun`. That frame is dropped. `res` and `res_valid` are held, and the state stays DONE.
- `res_ready` while not in DONE is ignored.
- `overrun` clears only on reset.
- `res` is updated only on the DONE entry edge and is otherwise stable.

## Timing
- Reset (`rst_n` = 0 at posedge) forces:
  - state = IDLE.
  - `res` = 0, `res_valid` = 0, `res_err` = 0, `busy` = 0, `overrun` = 0.
  - shift register and counters = 0.
- Reset during any state, including mid-SHIFT, discards the partial frame.
- Bit i (i = 0..19) is sampled at edge k0 + SKIP + i.
- `res_valid` rises after edge k0 + SKIP + 19, so latency is SKIP + 20 edges from k0.
- `busy` is 1 from the edge after k0 through the last sample edge; it is 0 while `res_valid` is 1.
- Handshake: transfer occurs on the edge where `res_valid` and `res_ready` are both 1. `res_valid` drops after that edge.
- The earliest next frame needs `en` high again, so back-to-back frames are separated by at least one ARMED cycle.
- All outputs are registered.

## Configuration
- BCD_CHECK_EN defined:
  - Five per-digit comparators (digit > 9) are evaluated on the assembled word at DONE entry.
  - `res_err` is registered alongside `res`.
- BCD_CHECK_EN undefined:
  - `res_err` is tied to 0 and no comparators are built.
  - All other behaviour is identical.

## Test plan
- Reset, then frame `en` 1 for 33 cycles then 0, with `sdata` carrying 20'h01234 MSB first and SKIP = 1 → `res_valid` rises 21 edges after k0, `res` = 20'h01234, `res_err` = 0.
- Same flow with 20'h1A999 (BCD_CHECK_EN defined) → `res` = 20'h1A999, `res_err` = 1. With BCD_CHECK_EN undefined → `res_err` = 0.
- Hold `res_ready` = 0 and run a second full frame (20'h00007) → `overrun` = 1, `res` stays 20'h01234. Then pulse `res_ready` → `res_valid` = 0 the next cycle.
- Raise `en` after 10 SHIFT samples → no `res_valid`, `busy` = 0, state ARMED. The next complete frame 20'h99999 is received correctly.
- Assert `rst_n` = 0 mid-SHIFT (bit 12) → all outputs 0 next edge. A subsequent frame 20'h50505 is received correctly.
- SKIP = 0 build with 20'h00001 → bit 0 is sampled at k0, and `res_valid` rises 20 edges after k0.
